// File: rtl/iram_port_arb_if.sv
// Purpose : handshake bundle between the instruction-fetch/program-load clients and iram_port_arb.
// Ports   : fetch_* = read-only req/gnt request plus rvalid/rready response; load_* = byte-masked write plus drop flag.
// Modports: slave = the RAM block, master = the client side.
interface iram_port_arb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic                  fetch_req;
   logic [ADDR_W-1:0]     fetch_addr;
   logic                  fetch_gnt;
   logic                  fetch_rvalid;
   logic [DATA_W-1:0]     fetch_rdata;
   logic                  fetch_err;
   logic                  fetch_rready;
   logic                  load_wr;
   logic [ADDR_W-1:0]     load_addr;
   logic [DATA_W-1:0]     load_wdata;
   logic [DATA_W/8-1:0]   load_be;
   logic                  load_err;

   modport slave (
      input  fetch_req, fetch_addr, fetch_rready,
      input  load_wr, load_addr, load_wdata, load_be,
      output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
      output load_err
   );

   modport master (
      output fetch_req, fetch_addr, fetch_rready,
      output load_wr, load_addr, load_wdata, load_be,
      input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
      input  load_err
   );
endinterface

// File: rtl/iram_port_arb.sv
// Purpose     : single-port word RAM shared by a read-only fetch port and a byte-masked program-load port.
// Latency     : write lands at the sampling edge; fetch granted at edge N responds from cycle N+1.
// Backpressure: load always wins; fetch_gnt drops while load_wr is high or the response register is held.
// Ports       : sclk, rstn (async active-low) plus bus (iram_port_arb_if.slave) carrying fetch_* and load_*.
module iram_port_arb #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8192,
   parameter int ADDR_W = 32
) (
   input  logic               sclk,
   input  logic               rstn,
   iram_port_arb_if.slave     bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int BS_W  = $clog2(DATA_W/8);
   localparam int NB    = DATA_W/8;

   typedef enum logic {RSP_EMPTY, RSP_FULL} rsp_state_t;

   rsp_state_t          state_q, state_d;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   rd_q;        // raw array read, no reset so it can sit in the RAM output register
   logic                err_q;
   logic                load_err_q;
   logic                gnt;
   logic                fetch_ok, load_ok;
   logic [IDX_W-1:0]    fetch_idx, load_idx;

   // Legal = word aligned and inside the array; out-of-range never wraps onto low words.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return ((a & ADDR_W'(NB-1)) == '0) && ((a >> BS_W) < ADDR_W'(DEPTH));
   endfunction

   assign fetch_ok  = addr_ok(bus.fetch_addr);
   assign load_ok   = addr_ok(bus.load_addr);
   assign fetch_idx = bus.fetch_addr[BS_W +: IDX_W];
   assign load_idx  = bus.load_addr[BS_W +: IDX_W];

   // rstn gating keeps the grant low throughout reset even with requests pending.
   assign gnt = rstn & bus.fetch_req & ~bus.load_wr &
                ((state_q == RSP_EMPTY) | bus.fetch_rready);

   // Array: only one access per cycle, since a write excludes the fetch grant.
   always_ff @(posedge sclk) begin
      if (bus.load_wr && load_ok) begin
         for (int i = 0; i < NB; i++) begin
            if (bus.load_be[i]) mem[load_idx][8*i +: 8] <= bus.load_wdata[8*i +: 8];
         end
      end
      if (gnt && fetch_ok) rd_q <= mem[fetch_idx];
   end

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= RSP_EMPTY;
         err_q      <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         load_err_q <= bus.load_wr & ~load_ok;
         if (gnt) err_q <= ~fetch_ok;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RSP_EMPTY: if (gnt) state_d = RSP_FULL;
         RSP_FULL:  if (gnt) state_d = RSP_FULL;
                    else if (bus.fetch_rready) state_d = RSP_EMPTY;
         default:   state_d = RSP_EMPTY;
      endcase
   end

   // Data is forced to zero for errored or absent responses, so rd_q needs no reset.
   assign bus.fetch_gnt    = gnt;
   assign bus.fetch_rvalid = (state_q == RSP_FULL);
   assign bus.fetch_err    = (state_q == RSP_FULL) & err_q;
   assign bus.fetch_rdata  = ((state_q == RSP_FULL) && !err_q) ? rd_q : '0;
   assign bus.load_err     = load_err_q;
endmodule

// File: tb/tb_iram_port_arb.sv
module tb_iram_port_arb;
   logic sclk = 1'b0;
   logic rstn;
   int   n_tests = 0;
   int   n_fail  = 0;

   iram_port_arb_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   iram_port_arb #(.DATA_W(32), .DEPTH(8192), .ADDR_W(32)) dut (
      .sclk (sclk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 sclk = ~sclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge sclk);
      #1;
   endtask

   task automatic load(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      bus.load_wr    = 1'b1;
      bus.load_addr  = addr;
      bus.load_wdata = data;
      bus.load_be    = be;
      step();
      bus.load_wr    = 1'b0;
      bus.load_be    = 4'h0;
   endtask

   task automatic fetch_one(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_d, input logic exp_e);
      bus.fetch_req    = 1'b1;
      bus.fetch_addr   = addr;
      bus.fetch_rready = 1'b1;
      #1 chk({tag, "_gnt"}, 32'(bus.fetch_gnt), 32'd1);
      step();
      bus.fetch_req = 1'b0;
      chk({tag, "_rvalid"}, 32'(bus.fetch_rvalid), 32'd1);
      chk({tag, "_rdata"},  bus.fetch_rdata, exp_d);
      chk({tag, "_err"},    32'(bus.fetch_err), 32'(exp_e));
   endtask

   initial begin
      // Reset with both ports requesting; illegal write address so nothing lands in the array.
      rstn             = 1'b0;
      bus.fetch_req    = 1'b1;
      bus.fetch_addr   = 32'h0;
      bus.fetch_rready = 1'b1;
      bus.load_wr      = 1'b1;
      bus.load_addr    = 32'h8000;
      bus.load_wdata   = 32'hFFFF_FFFF;
      bus.load_be      = 4'hF;
      step();
      step();
      chk("rst_gnt",      32'(bus.fetch_gnt),    32'd0);
      chk("rst_rvalid",   32'(bus.fetch_rvalid), 32'd0);
      chk("rst_rdata",    bus.fetch_rdata,       32'd0);
      chk("rst_err",      32'(bus.fetch_err),    32'd0);
      chk("rst_load_err", 32'(bus.load_err),     32'd0);
      rstn          = 1'b1;
      bus.fetch_req = 1'b0;
      bus.load_wr   = 1'b0;
      bus.load_be   = 4'h0;
      step();

      // Fill and read back.
      load(32'h0, 32'hDEAD_BEEF, 4'hF);
      chk("fill_load_err", 32'(bus.load_err), 32'd0);
      fetch_one("fill", 32'h0, 32'hDEAD_BEEF, 1'b0);

      // Byte masking and all-zero byte enable.
      load(32'h10, 32'h1122_3344, 4'hF);
      load(32'h10, 32'hAABB_CCDD, 4'b0101);
      fetch_one("mask", 32'h10, 32'h11BB_33DD, 1'b0);
      load(32'h10, 32'hFFFF_FFFF, 4'h0);
      fetch_one("be0", 32'h10, 32'h11BB_33DD, 1'b0);

      // Collision: load wins, fetch follows next cycle and sees the new word.
      bus.load_wr      = 1'b1;
      bus.load_addr    = 32'h20;
      bus.load_wdata   = 32'hCAFE_F00D;
      bus.load_be      = 4'hF;
      bus.fetch_req    = 1'b1;
      bus.fetch_addr   = 32'h20;
      bus.fetch_rready = 1'b1;
      #1 chk("coll_gnt0", 32'(bus.fetch_gnt), 32'd0);
      step();
      bus.load_wr = 1'b0;
      bus.load_be = 4'h0;
      chk("coll_rvalid0", 32'(bus.fetch_rvalid), 32'd0);
      #1 chk("coll_gnt1", 32'(bus.fetch_gnt), 32'd1);
      step();
      bus.fetch_req = 1'b0;
      chk("raw_rvalid", 32'(bus.fetch_rvalid), 32'd1);
      chk("raw_rdata",  bus.fetch_rdata, 32'hCAFE_F00D);

      // Backpressure: hold the first response three cycles, then drain in order.
      load(32'h4, 32'h4444_4444, 4'hF);
      load(32'h8, 32'h8888_8888, 4'hF);
      bus.fetch_req    = 1'b1;
      bus.fetch_addr   = 32'h0;
      bus.fetch_rready = 1'b1;
      #1 chk("bp_gnt_first", 32'(bus.fetch_gnt), 32'd1);
      step();
      bus.fetch_rready = 1'b0;
      bus.fetch_addr   = 32'h4;
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp_gnt_hold", 32'(bus.fetch_gnt), 32'd0);
         chk("bp_rvalid_hold", 32'(bus.fetch_rvalid), 32'd1);
         chk("bp_rdata_hold",  bus.fetch_rdata, 32'hDEAD_BEEF);
         step();
      end
      chk("bp_rdata_held", bus.fetch_rdata, 32'hDEAD_BEEF);
      bus.fetch_rready = 1'b1;
      #1 chk("bp_gnt_4", 32'(bus.fetch_gnt), 32'd1);
      step();
      chk("bp_rdata_4", bus.fetch_rdata, 32'h4444_4444);
      bus.fetch_addr = 32'h8;
      #1 chk("bp_gnt_8", 32'(bus.fetch_gnt), 32'd1);
      step();
      chk("bp_rdata_8", bus.fetch_rdata, 32'h8888_8888);
      bus.fetch_req = 1'b0;
      step();
      chk("bp_drained", 32'(bus.fetch_rvalid), 32'd0);

      // Error responses and the last legal word.
      fetch_one("misal", 32'h2, 32'h0, 1'b1);
      fetch_one("range", 32'h8000, 32'h0, 1'b1);
      load(32'h7FFC, 32'h1234_5678, 4'hF);
      chk("top_load_err", 32'(bus.load_err), 32'd0);
      fetch_one("top", 32'h7FFC, 32'h1234_5678, 1'b0);

      // Illegal write: one-cycle pulse, no wrap onto word 0.
      load(32'h8000, 32'h0BAD_0BAD, 4'hF);
      chk("lerr_pulse", 32'(bus.load_err), 32'd1);
      step();
      chk("lerr_clear", 32'(bus.load_err), 32'd0);
      fetch_one("nowrap", 32'h0, 32'hDEAD_BEEF, 1'b0);

      // Back-to-back illegal writes keep load_err high.
      bus.load_wr    = 1'b1;
      bus.load_addr  = 32'h8000;
      bus.load_wdata = 32'h0;
      bus.load_be    = 4'hF;
      step();
      chk("lerr_b2b_1", 32'(bus.load_err), 32'd1);
      bus.load_addr = 32'h1;
      step();
      chk("lerr_b2b_2", 32'(bus.load_err), 32'd1);
      bus.load_wr = 1'b0;
      bus.load_be = 4'h0;
      step();
      chk("lerr_b2b_end", 32'(bus.load_err), 32'd0);

      // Mid-stream reset: pending response dropped at once, RAM contents kept.
      bus.fetch_req    = 1'b1;
      bus.fetch_addr   = 32'h10;
      bus.fetch_rready = 1'b0;
      step();
      chk("mid_rvalid", 32'(bus.fetch_rvalid), 32'd1);
      chk("mid_rdata",  bus.fetch_rdata, 32'h11BB_33DD);
      #2 rstn = 1'b0;
      #1 chk("mid_rst_rvalid", 32'(bus.fetch_rvalid), 32'd0);
      chk("mid_rst_rdata", bus.fetch_rdata, 32'd0);
      chk("mid_rst_gnt",   32'(bus.fetch_gnt), 32'd0);
      step();
      rstn             = 1'b1;
      bus.fetch_req    = 1'b0;
      bus.fetch_rready = 1'b1;
      step();
      fetch_one("retain20", 32'h20, 32'hCAFE_F00D, 1'b0);
      fetch_one("retain0",  32'h0,  32'hDEAD_BEEF, 1'b0);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
